// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths and select-width helper for simple_bus
package bus_pkg;

  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefAddressWidth = 32;

  // Width of an index register selecting one of n ports (at least one bit)
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simple_bus_if.sv
// rtl/simple_bus_if.sv - host, device and address-map signals of simple_bus
interface simple_bus_if
  import bus_pkg::*;
#(
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned AddressWidth = DefAddressWidth
);

  localparam int unsigned BeWidth = DataWidth / 8;

  logic [NrHosts-1:0]      host_req_i;
  logic [NrHosts-1:0]      host_gnt_o;
  logic [AddressWidth-1:0] host_addr_i   [NrHosts];
  logic [NrHosts-1:0]      host_we_i;
  logic [BeWidth-1:0]      host_be_i     [NrHosts];
  logic [DataWidth-1:0]    host_wdata_i  [NrHosts];
  logic [NrHosts-1:0]      host_rvalid_o;
  logic [DataWidth-1:0]    host_rdata_o  [NrHosts];
  logic [NrHosts-1:0]      host_err_o;

  logic [NrDevices-1:0]    device_req_o;
  logic [AddressWidth-1:0] device_addr_o  [NrDevices];
  logic [NrDevices-1:0]    device_we_o;
  logic [BeWidth-1:0]      device_be_o    [NrDevices];
  logic [DataWidth-1:0]    device_wdata_o [NrDevices];
  logic [NrDevices-1:0]    device_rvalid_i;
  logic [DataWidth-1:0]    device_rdata_i [NrDevices];
  logic [NrDevices-1:0]    device_err_i;

  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices];
  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices];

  // Bus side: the crossbar itself
  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i, device_err_i,
    input  cfg_device_addr_base, cfg_device_addr_mask
  );

  // Environment side: hosts, devices and address map
  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i, device_err_i,
    output cfg_device_addr_base, cfg_device_addr_mask
  );

endinterface

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - base/mask address decoder, highest matching index wins
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned AddressWidth = DefAddressWidth,
  parameter int unsigned DevSelW      = sel_width(NrDevices)
) (
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [AddressWidth-1:0] base_i [NrDevices],
  input  logic [AddressWidth-1:0] mask_i [NrDevices],
  output logic [DevSelW-1:0]      dev_idx_o,
  output logic                    hit_o
);

  // Ascending scan so a later (higher-index) match overrides an earlier one
  always_comb begin
    dev_idx_o = '0;
    hit_o     = 1'b0;
    for (int d = 0; d < int'(NrDevices); d++) begin
      if ((addr_i & mask_i[d]) == base_i[d]) begin
        dev_idx_o = DevSelW'(d);
        hit_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_bus.sv
// rtl/simple_bus.sv - fixed-priority host-to-device crossbar; BUS_DECODE_ERR_EN enables unmapped-access error responses
module simple_bus
  import bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned AddressWidth = DefAddressWidth
) (
  input logic        clk_i,
  input logic        rst_ni,
  simple_bus_if.slave bus
);

  localparam int unsigned HostSelW = sel_width(NrHosts);
  localparam int unsigned DevSelW  = sel_width(NrDevices);
  localparam int unsigned BeWidth  = DataWidth / 8;

  logic                    accept;
  logic [HostSelW-1:0]     win_idx;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeWidth-1:0]      win_be;
  logic [DataWidth-1:0]    win_wdata;
  logic [DevSelW-1:0]      dec_idx;
  logic                    dec_hit;
  logic [DevSelW-1:0]      dev_target;
  logic [HostSelW-1:0]     host_sel_d, host_sel_q;
  logic [DevSelW-1:0]      device_sel_d, device_sel_q;
`ifdef BUS_DECODE_ERR_EN
  logic                    dec_err_d, dec_err_q;
`endif

  // Fixed-priority arbiter: descending scan leaves the lowest requester as winner
  always_comb begin
    accept  = 1'b0;
    win_idx = '0;
    for (int h = int'(NrHosts) - 1; h >= 0; h--) begin
      if (bus.host_req_i[h]) begin
        accept  = 1'b1;
        win_idx = HostSelW'(h);
      end
    end
  end

  assign win_addr  = bus.host_addr_i[win_idx];
  assign win_we    = bus.host_we_i[win_idx];
  assign win_be    = bus.host_be_i[win_idx];
  assign win_wdata = bus.host_wdata_i[win_idx];

  bus_addr_decode #(
    .NrDevices    (NrDevices),
    .AddressWidth (AddressWidth),
    .DevSelW      (DevSelW)
  ) u_decode (
    .addr_i    (win_addr),
    .base_i    (bus.cfg_device_addr_base),
    .mask_i    (bus.cfg_device_addr_mask),
    .dev_idx_o (dec_idx),
    .hit_o     (dec_hit)
  );

  // Unmapped accesses fall back to device 0 unless they are turned into errors
  assign dev_target = dec_hit ? dec_idx : '0;

  // Grant, request forwarding and broadcast of the winner's command
  always_comb begin
    bus.host_gnt_o = '0;
    if (accept) bus.host_gnt_o[win_idx] = 1'b1;
    for (int d = 0; d < int'(NrDevices); d++) begin
`ifdef BUS_DECODE_ERR_EN
      bus.device_req_o[d] = accept && dec_hit && (dev_target == DevSelW'(d));
`else
      bus.device_req_o[d] = accept && (dev_target == DevSelW'(d));
`endif
      bus.device_addr_o[d]  = win_addr;
      bus.device_we_o[d]    = win_we;
      bus.device_be_o[d]    = win_be;
      bus.device_wdata_o[d] = win_wdata;
    end
  end

  assign host_sel_d   = accept ? win_idx : host_sel_q;
  assign device_sel_d = accept ? dev_target : device_sel_q;
`ifdef BUS_DECODE_ERR_EN
  assign dec_err_d    = accept && !dec_hit;
`endif

  // Remember who asked and who answers so the next-cycle response can be routed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_sel_q   <= '0;
      device_sel_q <= '0;
`ifdef BUS_DECODE_ERR_EN
      dec_err_q    <= 1'b0;
`endif
    end else begin
      host_sel_q   <= host_sel_d;
      device_sel_q <= device_sel_d;
`ifdef BUS_DECODE_ERR_EN
      dec_err_q    <= dec_err_d;
`endif
    end
  end

  // Route the selected device's response to the originating host only
  always_comb begin
    for (int h = 0; h < int'(NrHosts); h++) begin
      bus.host_rvalid_o[h] = 1'b0;
      bus.host_rdata_o[h]  = '0;
      bus.host_err_o[h]    = 1'b0;
      if (host_sel_q == HostSelW'(h)) begin
`ifdef BUS_DECODE_ERR_EN
        if (dec_err_q) begin
          bus.host_rvalid_o[h] = 1'b1;
          bus.host_err_o[h]    = 1'b1;
        end else begin
          bus.host_rvalid_o[h] = bus.device_rvalid_i[device_sel_q];
          bus.host_rdata_o[h]  = bus.device_rdata_i[device_sel_q];
          bus.host_err_o[h]    = bus.device_err_i[device_sel_q];
        end
`else
        bus.host_rvalid_o[h] = bus.device_rvalid_i[device_sel_q];
        bus.host_rdata_o[h]  = bus.device_rdata_i[device_sel_q];
        bus.host_err_o[h]    = bus.device_err_i[device_sel_q];
`endif
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// tb/tb_simple_bus.sv - directed scoreboard bench for simple_bus (2 hosts, 3 devices)
module tb_simple_bus;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simple_bus_if #(.NrHosts(2), .NrDevices(3), .DataWidth(32), .AddressWidth(32)) bus_if ();

  simple_bus #(.NrDevices(3), .NrHosts(2), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  typedef struct {
    int          host;
    int          dev;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int h, input int d, input logic [31:0] r, input logic e);
    exp_t x;
    x.host = h; x.dev = d; x.rdata = r; x.err = e;
    return x;
  endfunction

  // One cycle: drive host requests and the device response owed to the oldest
  // expectation, then check the routed response at the host ports.
  task automatic step(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                      input logic we0, input logic [31:0] wd0);
    @(negedge clk);
    bus_if.host_req_i      = req;
    bus_if.host_addr_i[0]  = a0;
    bus_if.host_addr_i[1]  = a1;
    bus_if.host_we_i       = {1'b0, we0};
    bus_if.host_wdata_i[0] = wd0;
    bus_if.host_wdata_i[1] = 32'h0;
    bus_if.device_rvalid_i = '0;
    bus_if.device_err_i    = '0;
    for (int d = 0; d < 3; d++) bus_if.device_rdata_i[d] = 32'hBAD0_0000 | d;
    have_cur = (sb.size() > 0);
    if (have_cur) begin
      cur = sb.pop_front();
      if (cur.dev >= 0) begin
        bus_if.device_rvalid_i[cur.dev] = 1'b1;
        bus_if.device_rdata_i[cur.dev]  = cur.rdata;
        bus_if.device_err_i[cur.dev]    = cur.err;
      end
    end
    #1;
    if (have_cur) begin
      check("resp_rvalid", 32'(bus_if.host_rvalid_o[cur.host]), 32'd1);
      check("resp_rdata",  bus_if.host_rdata_o[cur.host], cur.rdata);
      check("resp_err",    32'(bus_if.host_err_o[cur.host]), 32'(cur.err));
      check("other_rvalid", 32'(bus_if.host_rvalid_o[1-cur.host]), 32'd0);
      check("other_rdata",  bus_if.host_rdata_o[1-cur.host], 32'd0);
    end else begin
      check("idle_rvalid", 32'(bus_if.host_rvalid_o), 32'd0);
    end
  endtask

  initial begin
    bus_if.host_req_i   = '0;
    bus_if.host_we_i    = '0;
    bus_if.device_rvalid_i = '0;
    bus_if.device_err_i = '0;
    for (int h = 0; h < 2; h++) begin
      bus_if.host_addr_i[h]  = '0;
      bus_if.host_be_i[h]    = 4'hF;
      bus_if.host_wdata_i[h] = '0;
    end
    for (int d = 0; d < 3; d++) bus_if.device_rdata_i[d] = '0;
    bus_if.cfg_device_addr_base[0] = 32'h0010_0000; bus_if.cfg_device_addr_mask[0] = ~32'hF_FFFF;
    bus_if.cfg_device_addr_base[1] = 32'h0002_0000; bus_if.cfg_device_addr_mask[1] = ~32'h3FF;
    bus_if.cfg_device_addr_base[2] = 32'h0003_0000; bus_if.cfg_device_addr_mask[2] = ~32'h3FF;

    // Reset state
    #12;
    check("rst_gnt",    32'(bus_if.host_gnt_o), 32'd0);
    check("rst_devreq", 32'(bus_if.device_req_o), 32'd0);
    check("rst_rvalid", 32'(bus_if.host_rvalid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Host0 write to RAM
    step(2'b01, 32'h0010_0010, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("wr_gnt",    32'(bus_if.host_gnt_o), 32'd1);
    check("wr_devreq", 32'(bus_if.device_req_o), 32'b001);
    check("wr_addr2",  bus_if.device_addr_o[2], 32'h0010_0010);
    check("wr_wdata0", bus_if.device_wdata_o[0], 32'hDEAD_BEEF);
    check("wr_we1",    32'(bus_if.device_we_o[1]), 32'd1);
    sb.push_back(mk(0, 0, 32'h0, 1'b0));

    // Host0 read from SimCtrl
    step(2'b01, 32'h0002_0008, 32'h0, 1'b0, 32'h0);
    check("sim_devreq", 32'(bus_if.device_req_o), 32'b010);
    check("sim_addr",   bus_if.device_addr_o[1], 32'h0002_0008);
    sb.push_back(mk(0, 1, 32'h1234_5678, 1'b0));

    // Host0 access to Timer, which answers with an error
    step(2'b01, 32'h0003_0000, 32'h0, 1'b0, 32'h0);
    check("tmr_devreq", 32'(bus_if.device_req_o), 32'b100);
    sb.push_back(mk(0, 2, 32'hCAFE_0000, 1'b1));

    step(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    check("idle_gnt",    32'(bus_if.host_gnt_o), 32'd0);
    check("idle_devreq", 32'(bus_if.device_req_o), 32'd0);

    // Both hosts request: host0 wins
    step(2'b11, 32'h0010_0020, 32'h0002_0010, 1'b0, 32'h0);
    check("prio_gnt",    32'(bus_if.host_gnt_o), 32'b01);
    check("prio_devreq", 32'(bus_if.device_req_o), 32'b001);
    check("prio_addr",   bus_if.device_addr_o[0], 32'h0010_0020);
    sb.push_back(mk(0, 0, 32'h1111_1111, 1'b0));

    // Host0 drops out: host1 is granted
    step(2'b10, 32'h0010_0020, 32'h0002_0010, 1'b0, 32'h0);
    check("h1_gnt",    32'(bus_if.host_gnt_o), 32'b10);
    check("h1_devreq", 32'(bus_if.device_req_o), 32'b010);
    check("h1_addr",   bus_if.device_addr_o[1], 32'h0002_0010);
    sb.push_back(mk(1, 1, 32'h2222_2222, 1'b0));

    step(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

    // Back-to-back RAM then Timer reads
    step(2'b01, 32'h0010_0040, 32'h0, 1'b0, 32'h0);
    check("b2b_ram_devreq", 32'(bus_if.device_req_o), 32'b001);
    sb.push_back(mk(0, 0, 32'hAAAA_0001, 1'b0));
    step(2'b01, 32'h0003_0004, 32'h0, 1'b0, 32'h0);
    check("b2b_tmr_devreq", 32'(bus_if.device_req_o), 32'b100);
    sb.push_back(mk(0, 2, 32'hBBBB_0002, 1'b0));
    step(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

    // Unmapped address
    step(2'b01, 32'h5000_0000, 32'h0, 1'b0, 32'h0);
    check("unmap_gnt", 32'(bus_if.host_gnt_o), 32'd1);
`ifdef BUS_DECODE_ERR_EN
    check("unmap_devreq", 32'(bus_if.device_req_o), 32'b000);
    sb.push_back(mk(0, -1, 32'h0, 1'b1));
`else
    check("unmap_devreq", 32'(bus_if.device_req_o), 32'b001);
    sb.push_back(mk(0, 0, 32'h5A5A_5A5A, 1'b0));
`endif
    step(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    step(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
